// File: rtl/tetris_block_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tetris_block_engine                                        |
// | Description : Single-cell falling-block game engine. Owns a 16x16        |
// |               playfield of 2-bit brightness codes and handles spawn,     |
// |               gravity, lateral moves, landing, full-row clear, score     |
// |               and game-over. Exposes a registered random-access pixel    |
// |               read port for the downstream matrix scanner.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  synchronous active-low reset
//   start      in   1  pulse, starts a game from IDLE or GAMEOVER
//   move_left  in   1  pulse, block column - 1 (FALL only)
//   move_right in   1  pulse, block column + 1 (FALL only)
//   drop_fast  in   1  level, selects the fast gravity period
//   rd_row     in   4  read row address (0 = floor, 15 = top)
//   rd_col     in   4  read column address
//   rd_pix     out  2  pixel code, 1-cycle latency: 0 empty, 2 settled,
//                      3 falling block
//   score      out  8  rows cleared, saturating at 255
//   game_over  out  1  high while in GAMEOVER
//   busy       out  1  high in every state except IDLE and GAMEOVER
//------------------------------------------------------------------------------
module tetris_block_engine #(
  parameter int DROP_TICKS = 800000,
  parameter int FAST_TICKS = 50000,
  parameter int SPAWN_X    = 3,
  parameter int SPAWN_Y    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       drop_fast,
  input  logic [3:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [1:0] rd_pix,
  output logic [7:0] score,
  output logic       game_over,
  output logic       busy
);

  // The counter only ever holds 0..limit-1, so clog2 of the larger limit
  // is wide enough.
  localparam int c_MAX_TICKS = (DROP_TICKS > FAST_TICKS) ? DROP_TICKS : FAST_TICKS;
  localparam int c_CNT_W     = (c_MAX_TICKS > 1) ? $clog2(c_MAX_TICKS) : 1;

  localparam logic [c_CNT_W-1:0] c_DROP_LIM = c_CNT_W'(DROP_TICKS - 1);
  localparam logic [c_CNT_W-1:0] c_FAST_LIM = c_CNT_W'(FAST_TICKS - 1);
  localparam logic [3:0]         c_SPAWN_X  = 4'(SPAWN_X);
  localparam logic [3:0]         c_SPAWN_Y  = 4'(SPAWN_Y);

  localparam logic [1:0] c_PIX_EMPTY   = 2'd0;
  localparam logic [1:0] c_PIX_SETTLED = 2'd2;
  localparam logic [1:0] c_PIX_FALLING = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SPAWN    = 3'd1,
    S_FALL     = 3'd2,
    S_LOCK     = 3'd3,
    S_CHECK    = 3'd4,
    S_CLEAR    = 3'd5,
    S_GAMEOVER = 3'd6
  } state_t;

  state_t             r_state;
  logic [1:0]         r_field [16][16];  // [row][col], row 0 is the floor
  logic [3:0]         r_x;
  logic [3:0]         r_y;
  logic [c_CNT_W-1:0] r_grav_cnt;
  logic               r_drop_pending;
  logic [7:0]         r_score;
  logic [1:0]         r_rd_pix;
  logic               r_game_over;
  logic               r_busy;

  logic [c_CNT_W-1:0] w_limit_m1;
  logic               w_tick;
  logic [3:0]         w_x_left;
  logic [3:0]         w_x_right;
  logic [3:0]         w_y_below;
  logic               w_left_ok;
  logic               w_right_ok;
  logic               w_land;
  logic               w_row_full;

  assign w_limit_m1 = drop_fast ? c_FAST_LIM : c_DROP_LIM;

  // Compare with >= so that switching to the shorter period while the count
  // is already past it produces a tick right away instead of running on.
  assign w_tick = (r_state == S_FALL) && (r_grav_cnt >= w_limit_m1);

  assign w_x_left  = r_x - 4'd1;
  assign w_x_right = r_x + 4'd1;
  assign w_y_below = r_y - 4'd1;

  // Simultaneous left and right cancel each other out.
  assign w_left_ok  = move_left && !move_right && (r_x != 4'd0) &&
                      (r_field[r_y][w_x_left] == c_PIX_EMPTY);
  assign w_right_ok = move_right && !move_left && (r_x != 4'd15) &&
                      (r_field[r_y][w_x_right] == c_PIX_EMPTY);

  assign w_land = (r_y == 4'd0) || (r_field[w_y_below][r_x] != c_PIX_EMPTY);

  // Blocks are single cells, so only the row just written can become full.
  always_comb begin
    w_row_full = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (r_field[r_y][c] == c_PIX_EMPTY) begin
        w_row_full = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_x            <= c_SPAWN_X;
      r_y            <= c_SPAWN_Y;
      r_grav_cnt     <= '0;
      r_drop_pending <= 1'b0;
      r_score        <= 8'd0;
      r_rd_pix       <= c_PIX_EMPTY;
      r_game_over    <= 1'b0;
      r_busy         <= 1'b0;
      for (int r = 0; r < 16; r++) begin
        for (int c = 0; c < 16; c++) begin
          r_field[r][c] <= c_PIX_EMPTY;
        end
      end
    end else begin
      // Read port: overlay the falling block on the stored field.
      if ((r_state == S_FALL) && (rd_row == r_y) && (rd_col == r_x)) begin
        r_rd_pix <= c_PIX_FALLING;
      end else begin
        r_rd_pix <= r_field[rd_row][rd_col];
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SPAWN;
            r_busy  <= 1'b1;
          end
        end

        S_SPAWN: begin
          r_x            <= c_SPAWN_X;
          r_y            <= c_SPAWN_Y;
          r_grav_cnt     <= '0;
          r_drop_pending <= 1'b0;
          if (r_field[c_SPAWN_Y][c_SPAWN_X] != c_PIX_EMPTY) begin
            r_state     <= S_GAMEOVER;
            r_busy      <= 1'b0;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_FALL;
          end
        end

        S_FALL: begin
          if (w_tick) begin
            r_grav_cnt <= '0;
          end else begin
            r_grav_cnt <= r_grav_cnt + 1'b1;
          end

          if (r_drop_pending) begin
            // Deferred gravity step, evaluated at the column the move
            // produced. Moves in this cycle are dropped; the pending cycle
            // always directly follows a move so nothing is starved.
            r_drop_pending <= 1'b0;
            if (w_land) begin
              r_state <= S_LOCK;
            end else begin
              r_y <= w_y_below;
            end
          end else if (w_left_ok || w_right_ok) begin
            // A move wins over a coincident tick; gravity follows next cycle.
            r_x <= w_left_ok ? w_x_left : w_x_right;
            if (w_tick) begin
              r_drop_pending <= 1'b1;
            end
          end else if (w_tick) begin
            if (w_land) begin
              r_state <= S_LOCK;
            end else begin
              r_y <= w_y_below;
            end
          end
        end

        S_LOCK: begin
          r_field[r_y][r_x] <= c_PIX_SETTLED;
          r_state           <= S_CHECK;
        end

        S_CHECK: begin
          r_state <= w_row_full ? S_CLEAR : S_SPAWN;
        end

        S_CLEAR: begin
          // Everything from the full row upward shifts down by one.
          for (int r = 0; r < 15; r++) begin
            if (4'(r) >= r_y) begin
              for (int c = 0; c < 16; c++) begin
                r_field[r][c] <= r_field[r+1][c];
              end
            end
          end
          for (int c = 0; c < 16; c++) begin
            r_field[15][c] <= c_PIX_EMPTY;
          end
          if (r_score != 8'hFF) begin
            r_score <= r_score + 8'd1;
          end
          r_state <= S_SPAWN;
        end

        S_GAMEOVER: begin
          if (start) begin
            for (int r = 0; r < 16; r++) begin
              for (int c = 0; c < 16; c++) begin
                r_field[r][c] <= c_PIX_EMPTY;
              end
            end
            r_score     <= 8'd0;
            r_game_over <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SPAWN;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign rd_pix    = r_rd_pix;
  assign score     = r_score;
  assign game_over = r_game_over;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tetris_block_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : tb_tetris_block_engine                                     |
// | Description : Directed self-checking bench for tetris_block_engine       |
// |               using DROP_TICKS=4, FAST_TICKS=2, spawn at (15,3).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
module tb_tetris_block_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       move_left;
  logic       move_right;
  logic       drop_fast;
  logic [3:0] rd_row;
  logic [3:0] rd_col;
  logic [1:0] rd_pix;
  logic [7:0] score;
  logic       game_over;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tetris_block_engine #(
    .DROP_TICKS(4),
    .FAST_TICKS(2),
    .SPAWN_X   (3),
    .SPAWN_Y   (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .move_left (move_left),
    .move_right(move_right),
    .drop_fast (drop_fast),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_pix    (rd_pix),
    .score     (score),
    .game_over (game_over),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are examined 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int r, input int c);
    rd_row = 4'(r);
    rd_col = 4'(c);
  endtask

  // Poll one address until it shows val; a timeout counts as a failure.
  task automatic wait_pix(input int r, input int c, input logic [1:0] val,
                          input int budget, input string name);
    bit seen = 1'b0;
    set_addr(r, c);
    for (int i = 0; i < budget; i++) begin
      step();
      if (rd_pix === val) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: pixel (%0d,%0d) never read %0d within %0d cycles, last %0d",
               name, r, c, val, budget, rd_pix);
    end
  endtask

  // Wait for a fresh spawn, steer to col (moves spaced by a gap cycle), then
  // drop fast until the block settles at (land_row, col). Returns one edge
  // after the lock write, i.e. with the engine in CHECK resolved.
  task automatic drop_to(input int col, input int land_row);
    wait_pix(15, 3, 2'd3, 300, "spawn");
    if (col < 3) begin
      repeat (3 - col) begin
        move_left = 1'b1; step(); move_left = 1'b0; step();
      end
    end else begin
      repeat (col - 3) begin
        move_right = 1'b1; step(); move_right = 1'b0; step();
      end
    end
    drop_fast = 1'b1;
    wait_pix(land_row, col, 2'd2, 300, "land");
    drop_fast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; move_left = 1'b0; move_right = 1'b0;
    drop_fast = 1'b0; set_addr(0, 0);
    repeat (3) step();
    checks++;
    if (score !== 8'd0 || game_over !== 1'b0 || busy !== 1'b0 || rd_pix !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: score=%0d go=%0d busy=%0d pix=%0d, need all 0",
               score, game_over, busy, rd_pix);
    end
    rst_n = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        set_addr(r, c);
        step();
        checks++;
        if (rd_pix !== 2'd0) begin
          failures++;
          $display("FAIL reset_field(%0d,%0d): got %0d need 0", r, c, rd_pix);
        end
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: got %0d need 0", busy);
    end
  endtask

  // Edge numbering E1.. starts at the start pulse.
  task automatic test_gravity();
    set_addr(15, 3);
    start = 1'b1; step(); start = 1'b0;        // E1 IDLE->SPAWN
    step();                                    // E2 read samples SPAWN
    checks++;
    if (rd_pix !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL spawn_cycle: pix=%0d busy=%0d need 0,1", rd_pix, busy);
    end
    step();                                    // E3 first FALL sample
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL fall_top: got %0d need 3", rd_pix);
    end
    repeat (3) step();                         // E6 last cycle at row 15
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL top_hold: got %0d need 3", rd_pix);
    end
    step();                                    // E7
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL top_vacated: got %0d need 0", rd_pix);
    end
    set_addr(14, 3); step();                   // E8
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL row14: got %0d need 3", rd_pix);
    end
    set_addr(0, 3); repeat (59) step();        // E67 LOCK cycle
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL lock_cycle: got %0d need 0", rd_pix);
    end
    step();                                    // E68
    checks++;
    if (rd_pix !== 2'd2) begin
      failures++; $display("FAIL settled_0_3: got %0d need 2", rd_pix);
    end
    set_addr(15, 3); step();                   // E69 read samples SPAWN
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL respawn_gap: got %0d need 0", rd_pix);
    end
    step();                                    // E70
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL respawn: got %0d need 3", rd_pix);
    end
  endtask

  // Continues from E70: block at (15,3), count 1, tick due at E73.
  task automatic test_move_left_wall();
    move_left = 1'b1; step();                  // E71 x=2
    step();                                    // E72 x=1
    move_left = 1'b0; set_addr(15, 1); step(); // E73 tick, y->14
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL left_x1: got %0d need 3", rd_pix);
    end
    move_left = 1'b1; step();                  // E74 x=0
    step();                                    // E75 4th pulse at wall
    move_left = 1'b0; set_addr(14, 0); step(); // E76
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL left_wall: got %0d need 3", rd_pix);
    end
    drop_fast = 1'b1;
    wait_pix(0, 0, 2'd2, 300, "land_0_0");
    drop_fast = 1'b0;
  endtask

  task automatic test_row_clear();
    bit seen = 1'b0;
    for (int c = 1; c < 15; c++) begin
      if (c != 3) drop_to(c, 0);
    end
    drop_to(5, 1);
    drop_to(15, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      if (score === 8'd1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL clear_score: got %0d need 1", score);
    end
  endtask

  // Runs right after the clear: the next block's tick coincides with a move.
  task automatic test_tick_move();
    wait_pix(15, 3, 2'd3, 50, "spawn_after_clear");   // Ek, count now 1
    step(); step();                                    // Ek+1, Ek+2
    move_right = 1'b1; step(); move_right = 1'b0;      // Ek+3 tick + move
    set_addr(15, 4); step();                           // Ek+4
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL tick_move_first: got %0d need 3", rd_pix);
    end
    set_addr(14, 4); step();                           // Ek+5
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL tick_move_descend: got %0d need 3", rd_pix);
    end
  endtask

  task automatic test_after_clear();
    set_addr(0, 5); step();
    checks++;
    if (rd_pix !== 2'd2) begin
      failures++; $display("FAIL shifted_0_5: got %0d need 2", rd_pix);
    end
    set_addr(1, 5); step();
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL shifted_1_5: got %0d need 0", rd_pix);
    end
    set_addr(0, 15); step();
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL shifted_0_15: got %0d need 0", rd_pix);
    end
    for (int c = 0; c < 16; c++) begin
      set_addr(15, c); step();
      checks++;
      if (rd_pix !== 2'd0) begin
        failures++; $display("FAIL top_row(15,%0d): got %0d need 0", c, rd_pix);
      end
    end
    drop_fast = 1'b1;
    wait_pix(0, 4, 2'd2, 300, "land_0_4");
    drop_fast = 1'b0;
  endtask

  task automatic test_blocked_move();
    for (int r = 0; r < 15; r++) drop_to(2, r);
    wait_pix(14, 3, 2'd3, 300, "reach_row14");         // D+1
    move_left = 1'b1; step(); move_left = 1'b0;        // D+2 blocked
    step();                                            // D+3
    checks++;
    if (rd_pix !== 2'd3) begin
      failures++; $display("FAIL left_blocked: got %0d need 3", rd_pix);
    end
    drop_fast = 1'b1;
    wait_pix(0, 3, 2'd2, 300, "land_0_3");
    drop_fast = 1'b0;
  endtask

  task automatic test_game_over();
    bit seen = 1'b0;
    for (int r = 1; r < 15; r++) drop_to(3, r);
    for (int i = 0; i < 100; i++) begin
      step();
      if (game_over === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || busy !== 1'b0 || score !== 8'd1) begin
      failures++;
      $display("FAIL game_over: go=%0d busy=%0d score=%0d need 1,0,1",
               game_over, busy, score);
    end
    set_addr(15, 3); step();
    checks++;
    if (rd_pix !== 2'd2) begin
      failures++; $display("FAIL over_top_cell: got %0d need 2", rd_pix);
    end
    set_addr(14, 2); step();
    checks++;
    if (rd_pix !== 2'd2) begin
      failures++; $display("FAIL over_14_2: got %0d need 2", rd_pix);
    end
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (game_over !== 1'b0 || busy !== 1'b1 || score !== 8'd0) begin
      failures++;
      $display("FAIL restart: go=%0d busy=%0d score=%0d need 0,1,0",
               game_over, busy, score);
    end
    step();
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL restart_14_2: got %0d need 0", rd_pix);
    end
    set_addr(0, 5); step();
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL restart_0_5: got %0d need 0", rd_pix);
    end
  endtask

  task automatic test_reset_during_clear();
    drop_fast = 1'b1;
    wait_pix(0, 3, 2'd2, 300, "land_restart");
    drop_fast = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c != 3) drop_to(c, 0);
    end
    drop_to(15, 0);        // engine now in CLEAR
    rst_n = 1'b0; step();
    checks++;
    if (score !== 8'd0 || game_over !== 1'b0 || busy !== 1'b0 || rd_pix !== 2'd0) begin
      failures++;
      $display("FAIL reset_in_clear: score=%0d go=%0d busy=%0d pix=%0d need all 0",
               score, game_over, busy, rd_pix);
    end
    rst_n = 1'b1; set_addr(0, 0); step();
    checks++;
    if (rd_pix !== 2'd0) begin
      failures++; $display("FAIL post_reset_0_0: got %0d need 0", rd_pix);
    end
    repeat (5) step();
    checks++;
    if (busy !== 1'b0 || score !== 8'd0) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%0d score=%0d need 0,0", busy, score);
    end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_move_left_wall();
    test_row_clear();
    test_tick_move();
    test_after_clear();
    test_blocked_move();
    test_game_over();
    test_reset_during_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_block_engine.md
Name: tetris_block_engine

Overview:
- Game-logic stage directly upstream of the 16x16 matrix scanner.
- Owns the 16x16 playfield of 2-bit brightness codes and runs a single-cell falling-block game: spawn, gravity, lateral moves, landing, full-row clear, score and game-over.
- Exposes a registered random-access pixel read port. The scanner addresses it by row/column each serial cycle instead of holding a hard-coded frame array.

Parameters:
- DROP_TICKS, 800000: clk cycles between gravity steps at normal speed.
- FAST_TICKS, 50000: clk cycles between gravity steps while drop_fast=1.
- SPAWN_X, 3: spawn column (0..15).
- SPAWN_Y, 15: spawn row (0..15); row 15 is the top, row 0 the floor.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a game from IDLE or GAMEOVER.
- move_left  in  1  one-cycle pulse; moves the block to column-1.
- move_right  in  1  one-cycle pulse; moves the block to column+1.
- drop_fast  in  1  level; selects FAST_TICKS gravity.
- rd_row  in  4  read row address.
- rd_col  in  4  read column address.
- rd_pix  out  2  pixel code: 0 empty, 2 settled, 3 falling block.
- score  out  8  rows cleared, saturating at 255.
- game_over  out  1  high while in GAMEOVER.
- busy  out  1  high in every state except IDLE and GAMEOVER.

Behaviour:
- Reset, sampled on the clk edge when rst_n=0:
  - playfield all 0, state IDLE, block (x,y)=(SPAWN_X,SPAWN_Y), gravity counter 0, drop_pending 0.
  - Outputs: score=0, rd_pix=0, game_over=0, busy=0.
  - A reset asserted mid-game, including during LOCK or CLEAR, fully overrides that cycle's update.
- Read port:
  - rd_pix is registered, 1-cycle latency.
  - Returns 3 if the state is FALL and (rd_row,rd_col)==(y,x); otherwise returns the stored cell.
  - Valid in all states; reads never stall the engine.
- Gravity counter:
  - Runs only in FALL. It emits a tick when the count reaches limit-1, then wraps to 0.
  - limit is FAST_TICKS if drop_fast=1, else DROP_TICKS.
  - If drop_fast changes while the count is already at or above the new limit, tick on the next cycle.
- States:
  - IDLE: on start -> SPAWN.
  - SPAWN, 1 cycle: set (x,y)=(SPAWN_X,SPAWN_Y). If cell[SPAWN_Y][SPAWN_X]!=0 -> GAMEOVER, otherwise -> FALL with the counter cleared.
  - FALL, moves:
    - move_left applies if x>0 and cell[y][x-1]==0.
    - move_right applies if x<15 and cell[y][x+1]==0.
    - A blocked move is silently dropped. move_left and move_right asserted together are both ignored.
  - FALL, gravity:
    - On a tick (or when drop_pending=1): if y==0 or cell[y-1][x]!=0 -> LOCK, otherwise y<=y-1.
    - If a tick and an applied move occur in the same cycle, apply the move only and set drop_pending. Gravity is then evaluated next cycle at the new x, and drop_pending is cleared.
  - LOCK, 1 cycle: write cell[y][x]<=2 -> CHECK.
  - CHECK, 1 cycle: if all 16 cells of row y are nonzero -> CLEAR, otherwise -> SPAWN. Only row y can become full, since blocks are single cells.
  - CLEAR, 1 cycle:
    - For r=y..14: row r <= row r+1. Row 15 <= all 0.
    - score <= score+1, saturating at 255 (no wrap).
    - -> SPAWN.
  - GAMEOVER: game_over=1, playfield frozen and readable. On start, clear the playfield, set score=0 and game_over=0 -> SPAWN.
- start is ignored in SPAWN, FALL, LOCK, CHECK and CLEAR.
- Move pulses are ignored outside FALL.
- Pulse inputs are already synchronised and debounced upstream.

Test Plan:
- Reset, then read all 256 addresses -> rd_pix=0 everywhere; score=0, game_over=0, busy=0.
- DROP_TICKS=4: start, no moves.
  - Block reads 3 at (15,3) and descends one row every 4 cycles.
  - Cell (0,3) reads 2 after lock; next block reads 3 at (15,3).
- move_left x4 from x=3 -> block stops at x=0 and the 4th pulse is ignored.
- With (14,2) settled, move_left at (14,3) -> x stays 3.
- Pre-fill row 0 columns 0..14 with 2, and (1,5)=2. Land a block at (0,15).
  - Row 0 clears and (0,5) now reads 2; row 15 is all 0; score=1.
- Fill column 3 up to row 14 and land one more block -> next SPAWN finds (15,3) occupied.
  - game_over=1 and busy=0.
  - start then clears all cells and sets score=0.
- Tick and move_right in the same cycle -> x+1 applied first; descent occurs on the next cycle.
- Assert rst_n=0 during CLEAR -> the next cycle shows reset values and the clear is not applied.
